// File: rtl/dual_port_byte_mem.sv
// Two-port, byte-addressed little-endian memory with per-byte write enables.
// Define MEM_REG_READ_EN for registered (1-cycle) reads; default reads are combinational.
module dual_port_byte_mem #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [DATA_WIDTH-1:0]   rdata_a,
    input  logic [DATA_WIDTH-1:0]   wdata_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic                    wen_a,
    input  logic [DATA_WIDTH/8-1:0] ben_a,
    output logic [DATA_WIDTH-1:0]   rdata_b,
    input  logic [DATA_WIDTH-1:0]   wdata_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic                    wen_b,
    input  logic [DATA_WIDTH/8-1:0] ben_b
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    logic [7:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] base_a, base_b;
    logic [DATA_WIDTH-1:0] word_a, word_b;

    // Unaligned addresses align down to the containing word.
    assign base_a = addr_a & ~ADDR_WIDTH'(NBYTES - 1);
    assign base_b = addr_b & ~ADDR_WIDTH'(NBYTES - 1);

    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int i = 0; i < NBYTES; i++) begin
            word_a[8*i +: 8] = mem[base_a + ADDR_WIDTH'(i)];
            word_b[8*i +: 8] = mem[base_b + ADDR_WIDTH'(i)];
        end
    end

    // Port a is applied last so it wins a same-byte collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                mem[j] <= '0;
        end else begin
            if (wen_b)
                for (int i = 0; i < NBYTES; i++)
                    if (ben_b[i]) mem[base_b + ADDR_WIDTH'(i)] <= wdata_b[8*i +: 8];
            if (wen_a)
                for (int i = 0; i < NBYTES; i++)
                    if (ben_a[i]) mem[base_a + ADDR_WIDTH'(i)] <= wdata_a[8*i +: 8];
        end
    end

`ifdef MEM_REG_READ_EN
    // Captures pre-write data on a same-cycle write to the same word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= word_a;
            rdata_b <= word_b;
        end
    end
`else
    assign rdata_a = rst ? '0 : word_a;
    assign rdata_b = rst ? '0 : word_b;
`endif

endmodule

// File: tb/tb_dual_port_byte_mem.sv
// Scoreboard bench for dual_port_byte_mem; expected words come from a byte model.
`timescale 1ns/1ps
module tb_dual_port_byte_mem;
    logic        clk = 0;
    logic        rst;
    logic [31:0] rdata_a, wdata_a, rdata_b, wdata_b;
    logic [15:0] addr_a, addr_b;
    logic        wen_a, wen_b;
    logic [3:0]  ben_a, ben_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  model [0:65535];

    always #5 clk = ~clk;

    dual_port_byte_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rdata_a(rdata_a), .wdata_a(wdata_a), .addr_a(addr_a), .wen_a(wen_a), .ben_a(ben_a),
        .rdata_b(rdata_b), .wdata_b(wdata_b), .addr_b(addr_b), .wen_b(wen_b), .ben_b(ben_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] got);
        logic [31:0] e;
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        check(tag, got, e);
    endtask

    function automatic logic [31:0] mword(input logic [15:0] a);
        logic [15:0] b;
        logic [31:0] w;
        b = a & 16'hFFFC;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = model[b + 16'(i)];
        return w;
    endfunction

    task automatic mwrite(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [15:0] b;
        b = a & 16'hFFFC;
        for (int i = 0; i < 4; i++) if (be[i]) model[b + 16'(i)] = d[8*i +: 8];
    endtask

    task automatic write_port(input bit pb, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        if (pb) begin addr_b = a; wdata_b = d; ben_b = be; wen_b = 1; end
        else    begin addr_a = a; wdata_a = d; ben_a = be; wen_a = 1; end
        mwrite(a, d, be);
        @(negedge clk);
        wen_a = 0; wen_b = 0; addr_b = 0;
    endtask

    task automatic rd_a(input string tag, input logic [15:0] a);
        @(negedge clk);
        addr_a = a;
        exp_q.push_back(mword(a));
`ifdef MEM_REG_READ_EN
        @(posedge clk); #1;
`else
        #1;
`endif
        pop_check(tag, rdata_a);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) model[i] = 0;
        rst = 1; wen_a = 0; wen_b = 0; addr_a = 0; addr_b = 0;
        wdata_a = 0; wdata_b = 0; ben_a = 0; ben_b = 0;
        repeat (2) @(negedge clk);
        rst = 0;

        rd_a("init_zero", 16'h0010);

        // Full-word write
        write_port(0, 16'h0010, 32'hDEADBEEF, 4'hF);
        rd_a("full_word", 16'h0010);
        check("mem10", {24'h0, dut.mem[16'h10]}, 32'hEF);
        check("mem11", {24'h0, dut.mem[16'h11]}, 32'hBE);
        check("mem12", {24'h0, dut.mem[16'h12]}, 32'hAD);
        check("mem13", {24'h0, dut.mem[16'h13]}, 32'hDE);

        // Byte-enable merge
        write_port(0, 16'h0010, 32'h11223344, 4'h6);
        rd_a("ben_merge", 16'h0010);
        check("ben_merge_const", mword(16'h0010), 32'hDE2233EF);

        // Alignment
        rd_a("align_read", 16'h0013);
        write_port(0, 16'h0012, 32'h000000AA, 4'h1);
        check("align_write", {24'h0, dut.mem[16'h10]}, 32'hAA);
        rd_a("align_word", 16'h0010);

        // wen=0 ignores ben
        @(negedge clk);
        addr_a = 16'h0010; wdata_a = 32'hFFFFFFFF; ben_a = 4'hF; wen_a = 0;
        @(negedge clk);
        rd_a("no_wen", 16'h0010);

        // Collision: port a wins
        @(negedge clk);
        addr_a = 16'h0020; wdata_a = 32'h0000AAAA; ben_a = 4'hF; wen_a = 1;
        addr_b = 16'h0020; wdata_b = 32'h0000BBBB; ben_b = 4'hF; wen_b = 1;
        mwrite(16'h0020, 32'h0000BBBB, 4'hF);
        mwrite(16'h0020, 32'h0000AAAA, 4'hF);
        @(negedge clk);
        wen_a = 0; wen_b = 0; addr_b = 0;
        rd_a("collision", 16'h0020);

        // Port b alone, read back through port a and port b
        write_port(1, 16'h0040, 32'h12345678, 4'hF);
        rd_a("portb_write", 16'h0040);
        @(negedge clk);
        addr_b = 16'h0040;
        exp_q.push_back(32'h12345678);
`ifdef MEM_REG_READ_EN
        @(posedge clk); #1;
`else
        #1;
`endif
        pop_check("portb_read", rdata_b);
        addr_b = 0;

        // Read during write to the same word
        write_port(0, 16'h0030, 32'h01020304, 4'hF);
        rd_a("rdw_setup", 16'h0030);
        @(negedge clk);
        addr_a = 16'h0030; wdata_a = 32'hA5A5A5A5; ben_a = 4'hF; wen_a = 1;
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'hA5A5A5A5);
`ifdef MEM_REG_READ_EN
        @(posedge clk); #1;
        pop_check("rdw_old", rdata_a);
        @(negedge clk); wen_a = 0;
        @(posedge clk); #1;
        pop_check("rdw_new", rdata_a);
`else
        #1;
        pop_check("rdw_old", rdata_a);
        @(posedge clk); #1;
        pop_check("rdw_new", rdata_a);
        @(negedge clk); wen_a = 0;
`endif
        mwrite(16'h0030, 32'hA5A5A5A5, 4'hF);

        // Top of memory
        write_port(0, 16'hFFFC, 32'hCAFEF00D, 4'hF);
        check("mem_ffff", {24'h0, dut.mem[16'hFFFF]}, 32'hCA);
        check("mem_0000", {24'h0, dut.mem[16'h0000]}, 32'h00);
`ifdef MEM_REG_READ_EN
        rd_a("top_prev", 16'h0040);
        @(negedge clk);
        addr_a = 16'hFFFC;
        exp_q.push_back(mword(16'h0040));
        exp_q.push_back(32'hCAFEF00D);
        #1;
        pop_check("top_latency", rdata_a);
        @(posedge clk); #1;
        pop_check("top_word", rdata_a);
`else
        rd_a("top_word", 16'hFFFC);
`endif

        // Mid-run reset with a write attempted during reset
        @(negedge clk);
        rst = 1;
        addr_a = 16'h0050; wdata_a = 32'h55667788; ben_a = 4'hF; wen_a = 1;
        for (int i = 0; i < 65536; i++) model[i] = 0;
        exp_q.push_back(32'h0);
        #1;
        pop_check("rst_rdata", rdata_a);
        @(posedge clk); #1;
        check("rst_mem10", {24'h0, dut.mem[16'h10]}, 32'h0);
        check("rst_memffff", {24'h0, dut.mem[16'hFFFF]}, 32'h0);
        check("rst_blocked", {24'h0, dut.mem[16'h50]}, 32'h0);
        exp_q.push_back(32'h0);
        pop_check("rst_rdata_hold", rdata_a);
        // Release with write still pending: accepted at the first edge
        @(negedge clk);
        rst = 0;
        mwrite(16'h0050, 32'h55667788, 4'hF);
        @(negedge clk);
        wen_a = 0;
        check("post_rst_write", {dut.mem[16'h53], dut.mem[16'h52], dut.mem[16'h51], dut.mem[16'h50]}, 32'h55667788);
        rd_a("post_rst_zero", 16'h0010);
        rd_a("post_rst_word", 16'h0050);
        rd_a("post_rst_top", 16'hFFFC);

        // Random traffic on both ports against the model
        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            a = 16'(($urandom_range(0, 15)) * 4 + 16'h0100);
            write_port(k[0], a, $urandom, 4'($urandom_range(0, 15)));
            rd_a("rand", 16'(a + 16'($urandom_range(0, 3))));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/dual_port_byte_mem.md
Name: dual_port_byte_mem

Overview:
- Simulation/FPGA-style unified memory with two independent 32-bit ports: port a serves core data loads/stores, port b serves instruction fetch or bench back-door.
- Storage is a byte array, little-endian, byte-addressed; each port reads and writes one word per access with per-byte write enables.
- Sits beside the core in the top-level bench; the bench also reads the byte array hierarchically for result checking.

Parameters:
- ADDR_WIDTH, 16, byte-address width; capacity = 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 32, port word width; must be a multiple of 8; NBYTES = DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all writes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdata_a  out  DATA_WIDTH  port a read data.
- wdata_a  in  DATA_WIDTH  port a write data.
- addr_a  in  ADDR_WIDTH  port a byte address.
- wen_a  in  1  port a write enable.
- ben_a  in  NBYTES  port a byte enables; bit i selects byte lane i.
- rdata_b, wdata_b, addr_b, wen_b, ben_b: same definitions for port b.

Behaviour:
- Storage: byte array named mem, indices 0..2**ADDR_WIDTH-1; the name is fixed for hierarchical access.
- Word base: addr with the low log2(NBYTES) bits forced to 0. Unaligned addresses silently align down; there is no misaligned split and no wrap-around.
- Read, default build: combinational. rdata_x[8i+:8] = mem[base+i] for i in 0..NBYTES-1. Zero latency. Independent of wen and ben.
- Write: on posedge clk, when wen_x=1 and ben_x[i]=1, mem[base+i] <= wdata_x[8i+:8]. Lanes with ben=0 are unchanged. wen=0 means no write regardless of ben.
- Read during write to the same word: rdata shows the old bytes until the clock edge and the new bytes after it.
- Simultaneous writes from both ports to the same byte in the same cycle: port a wins.
- Reset: while rst=1, every byte of mem is cleared to 0 asynchronously and all writes are blocked.
  - Default build: rdata_a and rdata_b read 0 during reset.
  - Release: the first write is accepted at the first posedge with rst=0.
- Port b tied off (wen_b=0, addr_b=0): port b is fully passive and has no side effects.
- No handshake signals, no stalls; every port is ready every cycle.

Optional Feature:
- Macro: MEM_REG_READ_EN.
- Defined: rdata_a and rdata_b are registered. Each is captured on posedge from the word at the current addr, giving 1-cycle read latency.
  - On a same-word write in the same cycle, the registered value is the pre-write data.
  - The rdata registers reset asynchronously to 0.
- Undefined: combinational read exactly as described in Behaviour.

Test Plan:
- Reset: assert rst mid-run after writes -> all of mem reads 0; rdata_a = 0x00000000 during and after reset until new writes.
- Full-word write: port a, addr=0x0010, wdata=0xDEADBEEF, ben=0xF, wen=1.
  - After the edge: rdata_a = 0xDEADBEEF.
  - Byte array: mem[0x10]=EF, mem[0x11]=BE, mem[0x12]=AD, mem[0x13]=DE.
- Byte-enable merge: starting from 0xDEADBEEF at 0x0010, write wdata=0x11223344, ben=0x6 -> word reads 0xDE2233EF.
- Alignment: read addr_a=0x0013 -> returns the word at 0x0010. Write addr=0x0012, ben=0x1, wdata=0x000000AA -> mem[0x10]=AA.
- Dual-port independence and collision:
  - Port a writes 0x0000AAAA and port b writes 0x0000BBBB to 0x0020, both ben=0xF, same cycle -> word = 0x0000AAAA.
  - Port b alone writes 0x12345678 at 0x0040 -> rdata_a at 0x0040 = 0x12345678.
- Top-of-memory: addr=0xFFFC, wdata=0xCAFEF00D, ben=0xF -> mem[0xFFFF]=CA, no wrap. With MEM_REG_READ_EN, rdata updates one cycle after the address is presented.
